mem_copy_master: RTL
====================

MEM_COPY_MASTER -- requirements
Module: mem_copy_master

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL set the address width of Mout_addr_ram, src_addr and dst_addr.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the number of wait cycles per access before an abort (range 1..255).
REQ-003 Port `clock`, input, width 1: sole clock; all state changes on the rising edge.
REQ-004 Port `reset`, input, width 1: asynchronous, active-low reset.
REQ-005 Port `start_port`, input, width 1: one-cycle request to begin a copy.
REQ-006 Port `src_addr`, input, width ADDR_W: first source byte address, sampled with start_port.
REQ-007 Port `dst_addr`, input, width ADDR_W: first destination byte address, sampled with start_port.
REQ-008 Port `len`, input, width 8: byte count, sampled with start_port.
REQ-009 Port `done_port`, output, width 1: one-cycle completion pulse.
REQ-010 Port `err_port`, output, width 1: sticky abort flag.
REQ-011 Port `Mout_oe_ram`, output, width 1: read request.
REQ-012 Port `Mout_we_ram`, output, width 1: write request.
REQ-013 Port `Mout_addr_ram`, output, width ADDR_W: byte address.
REQ-014 Port `Mout_Wdata_ram`, output, width 8: write data.
REQ-015 Port `Mout_data_ram_size`, output, width 4: access size in bits, constant 8 while a request is active.
REQ-016 Port `M_Rdata_ram`, input, width 8: read data, valid in a cycle where M_DataRdy=1 during a read.
REQ-017 Port `M_DataRdy`, input, width 1: the responder's completion strobe for the current request.

Function
REQ-018 States SHALL be IDLE, RD, WR, FIN, ERR.
REQ-019 IDLE with start_port=1 at an edge: latch src, dst and len; clear cnt and err_port; go to RD, or to FIN if len=0.
REQ-020 RD: assert Mout_oe_ram=1 and Mout_addr_ram=src+cnt, and hold both stable until M_DataRdy=1 is sampled.
REQ-021 RD with M_DataRdy=1 at an edge: capture M_Rdata_ram into the data register and go to WR.
REQ-022 WR: assert Mout_we_ram=1, Mout_addr_ram=dst+cnt and Mout_Wdata_ram=the data register, and hold all of them stable.
REQ-023 WR with M_DataRdy=1 at an edge: cnt+1; go to FIN if cnt+1=len, else go to RD.
REQ-024 Address sums SHALL wrap modulo 2^ADDR_W, and bytes SHALL be copied in ascending cnt order regardless of src/dst overlap.
REQ-025 Mout_oe_ram and Mout_we_ram SHALL never be 1 in the same cycle, and SHALL both be 0 outside RD/WR.
REQ-026 Mout_addr_ram, Mout_Wdata_ram and Mout_data_ram_size SHALL be 0 when no request is active.
REQ-027 The wait counter SHALL clear on entry to RD/WR and increment each cycle that M_DataRdy=0.
REQ-028 If the wait counter reaches TIMEOUT, the block SHALL go to ERR and drop its request lines on the next cycle.
REQ-029 FIN: done_port=1 for exactly one cycle, then go to IDLE.
REQ-030 ERR: err_port=1 and done_port=1 for one cycle, then go to IDLE; err_port stays 1 until the next accepted start.
REQ-031 start_port outside IDLE SHALL be ignored, with no effect on the transfer in progress.
REQ-032 M_DataRdy outside RD/WR SHALL be ignored.
REQ-033 Latency, with a responder giving 2-cycle reads and 1-cycle writes and start sampled at edge 0: the transfer occupies cycles 1..3N and done_port is high in cycle 3N+1.
REQ-034 Latency for len=0: done_port SHALL be high in cycle 1 with no memory access.

Reset
REQ-035 reset=0 SHALL immediately force: state IDLE, all outputs 0, cnt 0, wait counter 0, data register 0, err_port 0.
REQ-036 A reset asserted mid-transfer SHALL abort the transfer with no done_port pulse.
REQ-037 The first start SHALL be accepted at the first rising edge after reset is released.

Verification
REQ-038 Bench SHALL cover: responder with 2-cycle reads and 1-cycle writes, mem[0..3]=11,22,33,44, start src=0 dst=8 len=4 -> mem[8..11]=11,22,33,44; done_port in cycle 13; err_port=0.
REQ-039 Bench SHALL cover: start with len=0 -> done_port in cycle 1; oe and we never asserted.
REQ-040 Bench SHALL cover: src=126 dst=2 len=3 -> reads at addresses 126, 127, 0; writes at 2, 3, 4.
REQ-041 Bench SHALL cover: responder never raises M_DataRdy, TIMEOUT=4 -> oe held high for 4 cycles, then err_port=1 and a done_port pulse; err_port=1 persists until the next start clears it.
REQ-042 Bench SHALL cover: reset=0 during the second byte's WR state -> outputs 0 immediately; no done_port pulse; a new start after release completes normally.
REQ-043 Bench SHALL cover: start_port pulsed while in RD -> ignored; exactly len bytes are copied.

Source files
------------

// File: rtl/mem_copy_master.sv
// Byte-copy bus master: reads src+i then writes dst+i over a request/DataRdy RAM port,
// aborting with a sticky error flag when any single access waits TIMEOUT cycles.
module mem_copy_master #(
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_port,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [7:0]        len,
    output logic              done_port,
    output logic              err_port,
    output logic              Mout_oe_ram,
    output logic              Mout_we_ram,
    output logic [ADDR_W-1:0] Mout_addr_ram,
    output logic [7:0]        Mout_Wdata_ram,
    output logic [3:0]        Mout_data_ram_size,
    input  logic [7:0]        M_Rdata_ram,
    input  logic              M_DataRdy
);
    typedef enum logic [2:0] {IDLE, RD, WR, FIN, ERR} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [3:0] SIZE_BITS = 4'd8;

    state_t            state_reg;
    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [7:0]        len_reg;
    logic [7:0]        cnt_reg;
    logic [7:0]        wait_reg;
    logic [7:0]        data_reg;
    logic [7:0]        cnt_next;
    logic [7:0]        wait_next;
    logic              timed_out;

    assign cnt_next  = cnt_reg + 8'd1;
    assign wait_next = wait_reg + 8'd1;
    // A completion strobe in the same cycle the limit is reached still wins.
    assign timed_out = !M_DataRdy && (wait_next == TIMEOUT_C);

    // Write data is only driven while a write request is on the bus.
    assign Mout_Wdata_ram = Mout_we_ram ? data_reg : 8'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg          <= IDLE;
            src_reg            <= '0;
            dst_reg            <= '0;
            len_reg            <= '0;
            cnt_reg            <= '0;
            wait_reg           <= '0;
            data_reg           <= '0;
            done_port          <= 1'b0;
            err_port           <= 1'b0;
            Mout_oe_ram        <= 1'b0;
            Mout_we_ram        <= 1'b0;
            Mout_addr_ram      <= '0;
            Mout_data_ram_size <= '0;
        end else begin
            done_port <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_port) begin
                        src_reg  <= src_addr;
                        dst_reg  <= dst_addr;
                        len_reg  <= len;
                        cnt_reg  <= '0;
                        wait_reg <= '0;
                        err_port <= 1'b0;
                        if (len == 8'd0) begin
                            state_reg <= FIN;
                            done_port <= 1'b1;
                        end else begin
                            state_reg          <= RD;
                            Mout_oe_ram        <= 1'b1;
                            Mout_addr_ram      <= src_addr;
                            Mout_data_ram_size <= SIZE_BITS;
                        end
                    end
                end
                RD: begin
                    if (M_DataRdy) begin
                        state_reg     <= WR;
                        data_reg      <= M_Rdata_ram;
                        wait_reg      <= '0;
                        Mout_oe_ram   <= 1'b0;
                        Mout_we_ram   <= 1'b1;
                        Mout_addr_ram <= dst_reg + ADDR_W'(cnt_reg);
                    end else if (timed_out) begin
                        state_reg          <= ERR;
                        err_port           <= 1'b1;
                        done_port          <= 1'b1;
                        Mout_oe_ram        <= 1'b0;
                        Mout_we_ram        <= 1'b0;
                        Mout_addr_ram      <= '0;
                        Mout_data_ram_size <= '0;
                    end else begin
                        wait_reg <= wait_next;
                    end
                end
                WR: begin
                    if (M_DataRdy) begin
                        cnt_reg     <= cnt_next;
                        wait_reg    <= '0;
                        Mout_we_ram <= 1'b0;
                        if (cnt_next == len_reg) begin
                            state_reg          <= FIN;
                            done_port          <= 1'b1;
                            Mout_addr_ram      <= '0;
                            Mout_data_ram_size <= '0;
                        end else begin
                            state_reg     <= RD;
                            Mout_oe_ram   <= 1'b1;
                            Mout_addr_ram <= src_reg + ADDR_W'(cnt_next);
                        end
                    end else if (timed_out) begin
                        state_reg          <= ERR;
                        err_port           <= 1'b1;
                        done_port          <= 1'b1;
                        Mout_oe_ram        <= 1'b0;
                        Mout_we_ram        <= 1'b0;
                        Mout_addr_ram      <= '0;
                        Mout_data_ram_size <= '0;
                    end else begin
                        wait_reg <= wait_next;
                    end
                end
                FIN:     state_reg <= IDLE;
                ERR:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
